// File: rtl/s3_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : s3theta
// Purpose  : Stage-3 angle update for the hyperbolic CORDIC z path.
//            zOut = iData + step when iSign = 1, and iData - step when
//            iSign = 0. The step is 2^-4 when scomp = 1 and 2^-5 when
//            scomp = 0. When compin = 1, iData passes through unchanged.
// Ports    : iData  [DWIDTH-1:0] current angle residue
//            iSign               1 = add the step (residue is negative)
//            scomp               1 = step 2^-4, 0 = step 2^-5
//            compin              1 = residue already zero, hold it
//            zOut   [DWIDTH-1:0] updated residue
// Revision : 1.0 - initial release
// ============================================================================
module s3theta #(
    parameter int FRA_WIDTH = 13,
    parameter int DWIDTH    = 16
) (
    input  logic [DWIDTH-1:0] iData,
    input  logic              iSign,
    input  logic              scomp,
    input  logic              compin,
    output logic [DWIDTH-1:0] zOut
);
    localparam logic [DWIDTH-1:0] c_ONE   = {{(DWIDTH-1){1'b0}}, 1'b1};
    localparam logic [DWIDTH-1:0] c_STEP4 = c_ONE << (FRA_WIDTH - 4);
    localparam logic [DWIDTH-1:0] c_STEP5 = c_ONE << (FRA_WIDTH - 5);

    logic [DWIDTH-1:0] w_step;

    always_comb begin
        w_step = scomp ? c_STEP4 : c_STEP5;
        if (compin) begin
            zOut = iData;
        end else if (iSign) begin
            zOut = iData + w_step;
        end else begin
            zOut = iData - w_step;
        end
    end
endmodule

// ============================================================================
// Module   : s3_iter_ctrl
// Purpose  : Iterative stage-3 controller for the hyperbolic CORDIC
//            (rotation mode). This block accepts (x, y, z) over a valid/ready
//            handshake. It applies micro-rotations with shift 4, shift 4
//            again, and shift 5, one per cycle. It then holds the result
//            until the downstream block accepts it.
// Ports    : clk, rst                 clock, synchronous active-high reset
//            in_valid / in_ready      upstream handshake
//            x_in, y_in, z_in         stage-2 triple
//            out_valid / out_ready    downstream handshake
//            x_out, y_out, z_out      stage-3 result (registered)
//            rot_cnt [1:0]            count of non-bypassed micro-rotations
// Revision : 1.0 - initial release
// ============================================================================
module s3_iter_ctrl #(
    parameter int INT_WIDTH = 2,
    parameter int FRA_WIDTH = 13,
    parameter int DWIDTH    = 1 + INT_WIDTH + FRA_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] x_in,
    input  logic [DWIDTH-1:0] y_in,
    input  logic [DWIDTH-1:0] z_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] x_out,
    output logic [DWIDTH-1:0] y_out,
    output logic [DWIDTH-1:0] z_out,
    output logic [1:0]        rot_cnt
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_R4A  = 3'd1,
        S_R4B  = 3'd2,
        S_R5   = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t            state_q,     state_d;
    logic [DWIDTH-1:0] x_q,         x_d;
    logic [DWIDTH-1:0] y_q,         y_d;
    logic [DWIDTH-1:0] z_q,         z_d;
    logic [1:0]        rot_cnt_q,   rot_cnt_d;
    logic              out_valid_q, out_valid_d;

    logic                     w_scomp;
    logic                     w_z_zero;
    logic                     w_z_neg;
    logic                     w_accept;
    logic signed [DWIDTH-1:0] w_x_sh;
    logic signed [DWIDTH-1:0] w_y_sh;
    logic [DWIDTH-1:0]        w_z_next;

    // The two shift-4 states share the larger step. R5 uses the smaller one.
    assign w_scomp  = (state_q == S_R4A) || (state_q == S_R4B);
    assign w_z_zero = (z_q == '0);
    assign w_z_neg  = z_q[DWIDTH-1];

    // Arithmetic shifts of the pre-update x/y, so both updates see old values.
    assign w_x_sh = w_scomp ? ($signed(x_q) >>> 4) : ($signed(x_q) >>> 5);
    assign w_y_sh = w_scomp ? ($signed(y_q) >>> 4) : ($signed(y_q) >>> 5);

    s3theta #(
        .FRA_WIDTH (FRA_WIDTH),
        .DWIDTH    (DWIDTH)
    ) u_s3theta (
        .iData  (z_q),
        .iSign  (w_z_neg),
        .scomp  (w_scomp),
        .compin (w_z_zero),
        .zOut   (w_z_next)
    );

    // Ready is gated by reset so that nothing is accepted during reset.
    assign in_ready = ~rst & ((state_q == S_IDLE) ||
                              ((state_q == S_HOLD) && out_ready));
    assign w_accept = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        rot_cnt_d   = rot_cnt_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    x_d       = x_in;
                    y_d       = y_in;
                    z_d       = z_in;
                    rot_cnt_d = 2'd0;
                    state_d   = S_R4A;
                end
            end
            S_R4A, S_R4B, S_R5: begin
                // A zero residue bypasses the step entirely.
                if (!w_z_zero) begin
                    x_d       = w_z_neg ? (x_q - w_y_sh) : (x_q + w_y_sh);
                    y_d       = w_z_neg ? (y_q - w_x_sh) : (y_q + w_x_sh);
                    z_d       = w_z_next;
                    rot_cnt_d = rot_cnt_q + 2'd1;
                end
                if (state_q == S_R4A) begin
                    state_d = S_R4B;
                end else if (state_q == S_R4B) begin
                    state_d = S_R5;
                end else begin
                    state_d     = S_HOLD;
                    out_valid_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (w_accept) begin
                        x_d       = x_in;
                        y_d       = y_in;
                        z_d       = z_in;
                        rot_cnt_d = 2'd0;
                        state_d   = S_R4A;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            rot_cnt_q   <= 2'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            rot_cnt_q   <= rot_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign x_out     = x_q;
    assign y_out     = y_q;
    assign z_out     = z_q;
    assign rot_cnt   = rot_cnt_q;
    assign out_valid = out_valid_q;
endmodule
`default_nettype wire

// File: doc/s3_iter_ctrl.md
# s3_iter_ctrl

Iterative stage-3 controller for the hyperbolic CORDIC (rotation mode). Accepts an (x, y, z) triple from stage 2 over a valid/ready handshake, runs the three stage-3 micro-rotations sequentially (shift 4, repeated shift 4, shift 5), and presents the result to stage 4. The z path uses one s3theta instance, driven by `iSign`, `scomp` and `compin` signals generated here. The x/y updates and the control FSM are implemented in this block.

## Interface
- `INT_WIDTH`, default 2: integer bits of the fixed-point format.
- `FRA_WIDTH`, default 13: fraction bits. 1.0 = 0x2000 at the default.
- `DWIDTH`, default 1+INT_WIDTH+FRA_WIDTH (16): word width, two's complement.
- `clk` input 1: the single clock. All state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: upstream triple is valid.
- `in_ready` output 1: block can accept a triple this cycle.
- `x_in`, `y_in`, `z_in` input DWIDTH each: stage-2 results.
- `out_valid` output 1: result is valid.
- `out_ready` input 1: downstream accepts the result.
- `x_out`, `y_out`, `z_out` output DWIDTH each: stage-3 results, driven directly from registers.
- `rot_cnt` output 2: number of non-bypassed micro-rotations applied to the current result (0..3).

## Operation
- FSM states: IDLE, R4A, R4B, R5, HOLD.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: load x/y/z registers, clear `rot_cnt`, go to R4A.
- R4A and R4B (k=4), then R5 (k=5): each state is one micro-rotation in one cycle. R4A→R4B→R5→HOLD unconditionally.
- Per micro-rotation, with d = +1 if z ≥ 0 and −1 if z < 0 (sign bit):
  - x ← x + d·(y >>> k)
  - y ← y + d·(x >>> k)
  - z ← z − d·2^−k
  - Both x and y use the pre-update values (simultaneous update). `>>>` is an arithmetic shift.
- Wiring of the s3theta instance:
  - `iData`=z register.
  - `iSign`=z[DWIDTH−1] (1 selects add).
  - `scomp`=1 in R4A/R4B (2^−4 = 0x0200), 0 in R5 (2^−5 = 0x0100).
  - `compin`=(z==0).
  - The z register loads `zOut`.
- Bypass: if z == 0 at the start of a micro-rotation, x, y and z hold and `rot_cnt` does not increment. Otherwise `rot_cnt` increments.
- Arithmetic: modular wrap on overflow, no saturation, no rounding (shifted-out bits are discarded).
- HOLD:
  - `out_valid`=1. Outputs and `rot_cnt` are held stable while `out_ready`=0.
  - On `out_ready`=1 with `in_valid`=0: go to IDLE.
  - On `out_ready`=1 with `in_valid`=1: back-to-back accept, load the new triple and go to R4A.
- `in_ready` = (state==IDLE) | (state==HOLD & `out_ready`). It is forced to 0 while `rst`=1.

## Timing
- Reset (registered at the clock edge with `rst`=1):
  - state=IDLE; x/y/z registers=0; `rot_cnt`=0; `out_valid`=0.
  - `in_ready`=0 while `rst` is high and 1 on the first cycle after release.
- Latency: a triple accepted at edge E0 updates at E1, E2 and E3, and `out_valid`=1 from E3 onward. Output appears 3 cycles after the accept edge.
- Throughput: one triple per 4 cycles with `out_ready` held high (HOLD overlaps the next accept).
- Reset mid-operation: the in-flight triple is discarded and nothing is emitted. After release the FSM is in IDLE.
- `in_valid` outside an `in_ready` cycle is ignored. Input data is sampled only on the accept edge.
- `out_valid` stays high, with outputs stable, until `out_ready` is sampled high.

## Test plan
- Positive z, convergence with bypass:
  - Stimulus: x=0x2000, y=0x0000, z=0x0400.
  - Response: x_out=0x2020, y_out=0x0400, z_out=0x0000, rot_cnt=2. R5 is bypassed. `out_valid` rises 3 cycles after accept.
- Negative z:
  - Stimulus: x=0x2000, y=0x0000, z=0xFF00.
  - Intermediate: after R4A (x,y,z)=(0x2000,0xFE00,0x0100); after R4B (0x1FE0,0x0000,0xFF00).
  - Response: x_out=0x1FE0, y_out=0xFF01, z_out=0x0000, rot_cnt=3.
- Zero z:
  - Stimulus: x=0x1234, y=0x0567, z=0x0000.
  - Response: outputs equal inputs, rot_cnt=0.
- Backpressure and back-to-back:
  - Stimulus: hold `out_ready`=0 for 3 cycles in HOLD, with a second triple presented on `in_valid`.
  - Response: outputs stable and `in_ready`=0 during the stall. When `out_ready` rises, result 1 is taken and the second triple is accepted on the same edge. Result 2 appears 3 cycles later.
- Reset mid-operation:
  - Stimulus: assert `rst` for 1 cycle while in R4B.
  - Response: next cycle `out_valid`=0, outputs=0, `in_ready`=1. No result is emitted for the aborted triple.
- Overflow wrap:
  - Stimulus: x=0x7FFF, y=0x7FFF, z=0x0400.
  - Response: after R4A, x=y=0x87FE (wrapped) and z=0x0200. Ends with z_out=0x0000, rot_cnt=2. No saturation at any step.
